// File: rtl/seq_detect_param.sv
// Runtime-configurable serial pattern detector with Mealy/Moore output timing.
// Optional saturating match counter enabled by defining SEQ_MATCH_CNT_EN.
module seq_detect_param #(
   parameter  int PAT_W = 8,
   parameter  int MOORE = 0,
   parameter  int CNT_W = 16,
   localparam int LEN_W = $clog2(PAT_W + 1)
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             x,
   input  logic             in_valid,
   input  logic             cfg_load,
   input  logic [PAT_W-1:0] pat_in,
   input  logic [LEN_W-1:0] len_in,
   input  logic             overlap,
   output logic             y,
   output logic [CNT_W-1:0] match_cnt
);

   localparam logic [LEN_W-1:0] C_PAT_W = LEN_W'(PAT_W);

   logic [PAT_W-1:0] r_pat;
   logic [LEN_W-1:0] r_len;
   logic [PAT_W-1:0] r_hist;
   logic [LEN_W-1:0] r_fill;

   logic [PAT_W-1:0] w_win;
   logic [PAT_W-1:0] w_mask;
   logic [LEN_W:0]   w_fill_inc;
   logic             w_hit;

   assign w_win      = {r_hist[PAT_W-2:0], x};
   assign w_fill_inc = {1'b0, r_fill} + (LEN_W+1)'(1);

   // Only the low r_len bits of the window take part in the compare.
   always_comb begin
      w_mask = '0;
      for (int unsigned i = 0; i < PAT_W; i++) begin
         w_mask[i] = (i < 32'(r_len));
      end
   end

   assign w_hit = in_valid & ~cfg_load & (r_len != '0)
                & (w_fill_inc >= {1'b0, r_len})
                & (((w_win ^ r_pat) & w_mask) == '0);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_pat  <= '0;
         r_len  <= '0;
         r_hist <= '0;
         r_fill <= '0;
      end else if (cfg_load) begin
         r_pat  <= pat_in;
         r_len  <= (len_in > C_PAT_W) ? C_PAT_W : len_in;
         r_hist <= '0;
         r_fill <= '0;
      end else if (in_valid) begin
         r_hist <= w_win;
         if (w_hit && !overlap) begin
            r_fill <= '0;
         end else if (r_fill != C_PAT_W) begin
            r_fill <= r_fill + LEN_W'(1);
         end
      end
   end

   generate
      if (MOORE != 0) begin : g_moore
         logic r_y;
         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               r_y <= 1'b0;
            end else begin
               r_y <= w_hit;
            end
         end
         assign y = r_y;
      end else begin : g_mealy
         assign y = w_hit;
      end
   endgenerate

`ifdef SEQ_MATCH_CNT_EN
   logic [CNT_W-1:0] r_cnt;
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_cnt <= '0;
      end else if (w_hit && (r_cnt != '1)) begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end
   assign match_cnt = r_cnt;
`else
   assign match_cnt = '0;
`endif

endmodule

// File: tb/tb_seq_detect_param.sv
// Bench for seq_detect_param: Mealy and Moore instances share one stimulus
// stream and are checked against a queue-based model of received bits.
module tb_seq_detect_param;

   localparam int PAT_W = 8;
   localparam int LEN_W = 4;

   logic             clk = 1'b0;
   logic             reset_n;
   logic             x, in_valid, cfg_load, overlap;
   logic [PAT_W-1:0] pat_in;
   logic [LEN_W-1:0] len_in;
   logic             y0, y1;
   logic [1:0]       cnt0;
   logic [15:0]      cnt1;

   always #5 clk = ~clk;

   seq_detect_param #(.PAT_W(PAT_W), .MOORE(0), .CNT_W(2)) u_mealy (
      .clk(clk), .reset_n(reset_n), .x(x), .in_valid(in_valid), .cfg_load(cfg_load),
      .pat_in(pat_in), .len_in(len_in), .overlap(overlap), .y(y0), .match_cnt(cnt0));

   seq_detect_param #(.PAT_W(PAT_W), .MOORE(1), .CNT_W(16)) u_moore (
      .clk(clk), .reset_n(reset_n), .x(x), .in_valid(in_valid), .cfg_load(cfg_load),
      .pat_in(pat_in), .len_in(len_in), .overlap(overlap), .y(y1), .match_cnt(cnt1));

   int checks   = 0;
   int failures = 0;

   // Model: bits received since the last clear (newest at back) plus how many
   // bits count towards a match since the last load or non-overlap hit.
   bit               m_bits[$];
   int               m_count;
   int               m_len;
   logic [PAT_W-1:0] m_pat;
   bit               m_prev_hit;
   int               m_cnt0, m_cnt1;

`ifdef SEQ_MATCH_CNT_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic bit m_hit(input bit xb, input bit v, input bit ld);
      bit b;
      if (!v || ld || m_len == 0) return 1'b0;
      if (m_count + 1 < m_len) return 1'b0;
      for (int i = 0; i < m_len; i++) begin
         b = (i == 0) ? xb : m_bits[m_bits.size() - i];
         if (b != m_pat[i]) return 1'b0;
      end
      return 1'b1;
   endfunction

   task automatic m_reset();
      m_bits.delete();
      m_count    = 0;
      m_len      = 0;
      m_pat      = '0;
      m_prev_hit = 1'b0;
      m_cnt0     = 0;
      m_cnt1     = 0;
   endtask

   // One clock cycle: drive at the falling edge, check Mealy before the
   // rising edge, then Moore and counters just after it.
   task automatic step(input bit xb, input bit v, input bit ld, input logic [PAT_W-1:0] p,
                       input logic [LEN_W-1:0] l, input bit ov, input string tag);
      bit h;
      x = xb; in_valid = v; cfg_load = ld; pat_in = p; len_in = l; overlap = ov;
      #1;
      h = m_hit(xb, v, ld);
      chk({tag, "_mealy_y"}, 32'(y0), 32'(h));
      chk({tag, "_moore_hold"}, 32'(y1), 32'(m_prev_hit));
      @(posedge clk);
      #1;
      if (ld) begin
         m_pat = p;
         m_len = (int'(l) > PAT_W) ? PAT_W : int'(l);
         m_bits.delete();
         m_count = 0;
      end else if (v) begin
         m_bits.push_back(xb);
         if (m_bits.size() > PAT_W) void'(m_bits.pop_front());
         if (h && !ov) m_count = 0;
         else m_count++;
      end
      if (h && m_cnt0 < 3) m_cnt0++;
      if (h && m_cnt1 < 65535) m_cnt1++;
      m_prev_hit = h;
      chk({tag, "_moore_y"}, 32'(y1), 32'(h));
      chk({tag, "_cnt2"}, 32'(cnt0), CNT_EN ? 32'(m_cnt0) : 32'd0);
      chk({tag, "_cnt16"}, 32'(cnt1), CNT_EN ? 32'(m_cnt1) : 32'd0);
      @(negedge clk);
   endtask

   task automatic bits(input logic [15:0] seq, input int n, input bit ov, input string tag);
      for (int i = n - 1; i >= 0; i--) step(seq[i], 1'b1, 1'b0, '0, '0, ov, tag);
   endtask

   initial begin
      reset_n = 1'b0; x = 1'b0; in_valid = 1'b0; cfg_load = 1'b0;
      overlap = 1'b0; pat_in = '0; len_in = '0;
      m_reset();
      #12;
      chk("rst_mealy_y", 32'(y0), 32'd0);
      chk("rst_moore_y", 32'(y1), 32'd0);
      chk("rst_cnt2", 32'(cnt0), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;

      // "110" non-overlapping: hits on bits 3 and 6
      step(1'b0, 1'b0, 1'b1, 8'b110, 4'd3, 1'b0, "ld110");
      bits(16'b110110, 6, 1'b0, "basic");

      // "1011" overlapping then non-overlapping
      step(1'b0, 1'b0, 1'b1, 8'b1011, 4'd4, 1'b1, "ld1011");
      bits(16'b1011011, 7, 1'b1, "ovl1");
      step(1'b0, 1'b0, 1'b1, 8'b1011, 4'd4, 1'b0, "ld1011b");
      bits(16'b1011011, 7, 1'b0, "ovl0");

      // stall between the two ones
      step(1'b0, 1'b0, 1'b1, 8'b110, 4'd3, 1'b0, "ld_stall");
      step(1'b1, 1'b1, 1'b0, '0, '0, 1'b0, "stall_a");
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, "stall_gap");
      step(1'b1, 1'b1, 1'b0, '0, '0, 1'b0, "stall_b");
      step(1'b0, 1'b1, 1'b0, '0, '0, 1'b0, "stall_c");

      // reconfigure mid-pattern, x in the load cycle is discarded
      step(1'b0, 1'b0, 1'b1, 8'b110, 4'd3, 1'b0, "ld_recfg");
      bits(16'b11, 2, 1'b0, "recfg_pre");
      step(1'b0, 1'b1, 1'b1, 8'b01, 4'd2, 1'b0, "recfg_ld");
      bits(16'b01, 2, 1'b0, "recfg_post");

      // length clamp and disabled detector
      step(1'b0, 1'b0, 1'b1, 8'hA5, 4'd15, 1'b1, "ld_clamp");
      bits(16'hA5A5, 16, 1'b1, "clamp");
      step(1'b0, 1'b0, 1'b1, 8'hFF, 4'd0, 1'b1, "ld_dis");
      bits(16'hFFFF, 4, 1'b1, "disabled");

      // single-bit pattern: back-to-back hits, counter saturation
      step(1'b0, 1'b0, 1'b1, 8'b1, 4'd1, 1'b1, "ld_one");
      bits(16'b11111, 5, 1'b1, "sat");

      // asynchronous reset while Moore output is high
      reset_n = 1'b0;
      #1;
      chk("arst_moore_y", 32'(y1), 32'd0);
      chk("arst_mealy_y", 32'(y0), 32'd0);
      chk("arst_cnt2", 32'(cnt0), 32'd0);
      chk("arst_cnt16", 32'(cnt1), 32'd0);
      m_reset();
      @(negedge clk);
      reset_n = 1'b1;
      step(1'b1, 1'b1, 1'b0, '0, '0, 1'b1, "post_rst");

      // randomized traffic
      for (int n = 0; n < 800; n++) begin
         bit ld, v, xb, ov;
         logic [LEN_W-1:0] l;
         logic [PAT_W-1:0] p;
         ld = ($urandom_range(0, 24) == 0);
         v  = ($urandom_range(0, 4) != 0);
         xb = 1'($urandom_range(0, 1));
         ov = 1'($urandom_range(0, 1));
         p  = PAT_W'($urandom);
         l  = ($urandom_range(0, 3) == 0) ? LEN_W'($urandom_range(0, 15))
                                          : LEN_W'($urandom_range(1, 4));
         step(xb, v, ld, p, l, ov, "rand");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
